// File: rtl/gpu_cmd_pkg.sv
// Shared command-path definitions: opcodes, CMD/BUSY bit positions, payload
// field offsets, vertex loader state encoding and error bit positions.
package gpu_cmd_pkg;

  localparam int unsigned CMD_W = 8;
  localparam logic [CMD_W-1:0] OP_LOAD_VERTEX_BEGIN = 8'h04;
  localparam logic [CMD_W-1:0] OP_LOAD_VERTEX_CONT  = 8'h08;

  localparam int unsigned CMD_BIT_LOAD_BEGIN = 2;
  localparam int unsigned CMD_BIT_LOAD_CONT  = 3;
  localparam int unsigned BUSY_BIT_VTX_LOAD  = 2;

  // BEGIN: count in the low bits, base address from bit 16; CONT: {y, x}
  localparam int unsigned BEGIN_COUNT_LSB = 0;
  localparam int unsigned BEGIN_BASE_LSB  = 16;
  localparam int unsigned CONT_X_LSB      = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } vl_state_e;

  localparam int unsigned ERR_W     = 3;
  localparam int unsigned ERR_OVF   = 0;
  localparam int unsigned ERR_XCONT = 1;
  localparam int unsigned ERR_TMO   = 2;

endpackage

// File: rtl/vertex_loader_if.sv
// Command strobes, vertex RAM write port and status between the command
// decoder side (master) and the vertex loader (slave).
interface vertex_loader_if
  import gpu_cmd_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned COORD_W = 16
) ();

  logic                   cmd_begin;
  logic                   cmd_cont;
  logic [2*COORD_W-1:0]   payload;
  logic                   busy;
  logic                   vram_we;
  logic [ADDR_W-1:0]      vram_addr;
  logic [2*COORD_W-1:0]   vram_wdata;
  logic                   vram_ready;
  logic                   done;
  logic [ADDR_W-1:0]      vertex_count;
  logic [ERR_W-1:0]       err;

  modport master (
    output cmd_begin, cmd_cont, payload, vram_ready,
    input  busy, vram_we, vram_addr, vram_wdata, done, vertex_count, err
  );

  modport slave (
    input  cmd_begin, cmd_cont, payload, vram_ready,
    output busy, vram_we, vram_addr, vram_wdata, done, vertex_count, err
  );

endinterface

// File: rtl/vtx_skid_fifo.sv
// Two-entry FIFO between CONT strobes and the vertex RAM write port.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module vtx_skid_fifo #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [1:0]   level_o
);

  logic [W-1:0] mem_q [2];
  logic         rd_q;
  logic         wr_q;
  logic [1:0]   level_q;
  logic [1:0]   level_d;
  logic         pop_ok;
  logic         push_ok;

  assign empty_o = (level_q == 2'd0);
  assign full_o  = (level_q == 2'd2);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_q];

  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    level_d = level_q + 2'(push_ok) - 2'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      level_q  <= 2'd0;
    end else begin
      if (push_ok) mem_q[wr_q] <= wdata_i;
      if (flush_i) begin
        rd_q    <= 1'b0;
        wr_q    <= 1'b0;
        level_q <= 2'd0;
      end else begin
        if (push_ok) wr_q <= ~wr_q;
        if (pop_ok)  rd_q <= ~rd_q;
        level_q <= level_d;
      end
    end
  end

endmodule

// File: rtl/vertex_loader.sv
// Vertex load sequencer: takes BEGIN/CONT strobes, buffers coordinates and
// writes them to consecutive vertex RAM addresses, with done/busy/err status.
module vertex_loader
  import gpu_cmd_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned COORD_W     = 16,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic          CLK,
  input  logic          rst,
  vertex_loader_if.slave bus
);

  localparam int unsigned DATA_W = 2 * COORD_W;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC + 1);

  vl_state_e          state_q, state_d;
  logic [ADDR_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0]  rx_q, rx_d;
  logic [ADDR_W-1:0]  wptr_q, wptr_d;
  logic [ADDR_W-1:0]  vcnt_q, vcnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               finish;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_flush;
  logic               fifo_full;
  logic               fifo_empty;
  logic [1:0]         fifo_level;
  logic [DATA_W-1:0]  fifo_rdata;

  logic               hs;
  logic               begin_ok;
  logic [ADDR_W-1:0]  begin_cnt;
  logic [ADDR_W-1:0]  begin_base;
  logic [ADDR_W-1:0]  rx_inc;
  logic [TMO_W-1:0]   tmo_inc;

  assign hs         = ~fifo_empty & bus.vram_ready;
  assign fifo_pop   = hs;
  assign fifo_push  = (state_q == ST_LOAD) & bus.cmd_cont;
  // Holding off BEGIN through the done cycle keeps done pulses from abutting
  assign begin_ok   = bus.cmd_begin & ~busy_q & ~done_q;
  assign begin_cnt  = bus.payload[BEGIN_COUNT_LSB +: ADDR_W];
  assign begin_base = bus.payload[BEGIN_BASE_LSB +: ADDR_W];
  assign rx_inc     = rx_q + ADDR_W'(1);
  assign tmo_inc    = tmo_q + TMO_W'(1);

  vtx_skid_fifo #(.W(DATA_W)) u_fifo (
    .clk     (CLK),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .wdata_i (bus.payload),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      rx_q    <= '0;
      wptr_q  <= '0;
      vcnt_q  <= '0;
      tmo_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rx_q    <= rx_d;
      wptr_q  <= wptr_d;
      vcnt_q  <= vcnt_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rx_d       = rx_q;
    wptr_d     = wptr_q;
    vcnt_d     = vcnt_q;
    tmo_d      = tmo_q;
    err_d      = err_q;
    done_d     = 1'b0;
    finish     = 1'b0;
    fifo_flush = 1'b0;

    if (hs) wptr_d = wptr_q + ADDR_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (begin_ok) begin
          err_d  = '0;
          vcnt_d = begin_cnt;
          if (begin_cnt == '0) begin
            done_d = 1'b1;
          end else begin
            count_d = begin_cnt;
            wptr_d  = begin_base;
            rx_d    = '0;
            tmo_d   = '0;
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        tmo_d = tmo_inc;
        if (bus.cmd_cont) begin
          tmo_d = '0;
          rx_d  = rx_inc;
          if (fifo_full && !hs) err_d[ERR_OVF] = 1'b1;
          if (rx_inc == count_q) state_d = ST_DRAIN;
        end else if (tmo_inc == TMO_W'(TIMEOUT_CYC)) begin
          err_d[ERR_TMO] = 1'b1;
          fifo_flush     = 1'b1;
          state_d        = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (bus.cmd_cont) err_d[ERR_XCONT] = 1'b1;
        // Done once the last buffered vertex is handed to the RAM
        if (fifo_empty || (hs && fifo_level == 2'd1)) begin
          done_d  = 1'b1;
          finish  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE) || finish;
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.vertex_count = vcnt_q;
  assign bus.vram_we      = ~fifo_empty;
  assign bus.vram_addr    = wptr_q;
  assign bus.vram_wdata   = fifo_rdata;

endmodule

// File: tb/tb_vertex_loader.sv
// Bench for vertex_loader: expected RAM writes are queued as stimulus is
// driven and matched against every observed write handshake.
module tb_vertex_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vertex_loader_if #(.ADDR_W(8), .COORD_W(16)) vif ();

  vertex_loader #(.ADDR_W(8), .COORD_W(16), .TIMEOUT_CYC(16)) dut (
    .CLK (clk),
    .rst (rst),
    .bus (vif.slave)
  );

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  passed = 0;
  int  done_cnt = 0;
  bit  busy_seen = 1'b0;
  bit  we_seen = 1'b0;

  // Write monitor / scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (vif.done === 1'b1) done_cnt++;
      if (vif.busy === 1'b1) busy_seen = 1'b1;
      if (vif.vram_we === 1'b1) we_seen = 1'b1;
      if (vif.vram_we === 1'b1 && vif.vram_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL vram_write: got addr=%h data=%h, expected no write", vif.vram_addr, vif.vram_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          if (vif.vram_addr !== mon_e.addr || vif.vram_wdata !== mon_e.data)
            $display("FAIL vram_write: got addr=%h data=%h, expected addr=%h data=%h",
                     vif.vram_addr, vif.vram_wdata, mon_e.addr, mon_e.data);
          else passed++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_begin(input logic [7:0] cnt, input logic [7:0] base);
    vif.payload   = {8'h00, base, 8'h00, cnt};
    vif.cmd_begin = 1'b1;
    tick();
    vif.cmd_begin = 1'b0;
    vif.payload   = '0;
  endtask

  task automatic send_cont(input logic [31:0] d);
    vif.payload  = d;
    vif.cmd_cont = 1'b1;
    tick();
    vif.cmd_cont = 1'b0;
    vif.payload  = '0;
  endtask

  task automatic expect_wr(input logic [7:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (vif.done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    vif.cmd_begin = 1'b0;
    vif.cmd_cont = 1'b0;
    vif.payload = '0;
    vif.vram_ready = 1'b1;
    tick();
    tick();
    checks++;
    if ({vif.busy, vif.vram_we, vif.done, vif.err} !== 6'b0)
      $display("FAIL reset_ctrl: got busy=%b we=%b done=%b err=%b, expected all 0", vif.busy, vif.vram_we, vif.done, vif.err);
    else passed++;
    checks++;
    if ({vif.vram_addr, vif.vram_wdata, vif.vertex_count} !== 48'h0)
      $display("FAIL reset_data: got addr=%h wdata=%h vcnt=%h, expected 0", vif.vram_addr, vif.vram_wdata, vif.vertex_count);
    else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    vif.vram_ready = 1'b1;
    done_cnt = 0;
    expect_wr(8'h10, 32'h0002_0001);
    expect_wr(8'h11, 32'h0004_0003);
    expect_wr(8'h12, 32'h0006_0005);
    send_begin(8'd3, 8'h10);
    checks++;
    if (vif.busy !== 1'b1) $display("FAIL basic_busy_rise: got %b expected 1", vif.busy);
    else passed++;
    send_cont(32'h0002_0001);
    send_cont(32'h0004_0003);
    send_cont(32'h0006_0005);
    wait_done(8, lat);
    checks++;
    if (lat !== 1) $display("FAIL basic_done_latency: got %0d expected 1", lat);
    else passed++;
    checks++;
    if (vif.busy !== 1'b1) $display("FAIL basic_busy_in_done: got %b expected 1", vif.busy);
    else passed++;
    tick();
    checks++;
    if (vif.busy !== 1'b0 || vif.done !== 1'b0)
      $display("FAIL basic_after_done: got busy=%b done=%b expected 0 0", vif.busy, vif.done);
    else passed++;
    checks++;
    if (vif.err !== 3'b000 || vif.vertex_count !== 8'd3)
      $display("FAIL basic_status: got err=%b vcnt=%0d expected 000 3", vif.err, vif.vertex_count);
    else passed++;
    tick();
    tick();
    checks++;
    if (done_cnt !== 1 || exp_q.size() !== 0)
      $display("FAIL basic_done_count: got done=%0d pending=%0d expected 1 0", done_cnt, exp_q.size());
    else passed++;
  endtask

  task automatic test_wrap();
    int lat;
    vif.vram_ready = 1'b1;
    expect_wr(8'hFE, 32'hAAAA_0001);
    expect_wr(8'hFF, 32'hBBBB_0002);
    expect_wr(8'h00, 32'hCCCC_0003);
    send_begin(8'd3, 8'hFE);
    send_cont(32'hAAAA_0001);
    send_cont(32'hBBBB_0002);
    send_cont(32'hCCCC_0003);
    wait_done(8, lat);
    checks++;
    if (lat !== 1) $display("FAIL wrap_done_latency: got %0d expected 1", lat);
    else passed++;
    tick();
    checks++;
    if (vif.err !== 3'b000 || exp_q.size() !== 0)
      $display("FAIL wrap_status: got err=%b pending=%0d expected 000 0", vif.err, exp_q.size());
    else passed++;
  endtask

  task automatic test_overflow();
    int lat;
    vif.vram_ready = 1'b0;
    done_cnt = 0;
    expect_wr(8'h20, 32'h0001_1111);
    expect_wr(8'h21, 32'h0002_2222);
    send_begin(8'd4, 8'h20);
    send_cont(32'h0001_1111);
    send_cont(32'h0002_2222);
    send_cont(32'h0003_3333);
    send_cont(32'h0004_4444);
    repeat (5) tick();
    checks++;
    if (vif.vram_we !== 1'b1 || vif.vram_addr !== 8'h20 || vif.vram_wdata !== 32'h0001_1111)
      $display("FAIL ovf_hold: got we=%b addr=%h data=%h expected 1 20 00011111", vif.vram_we, vif.vram_addr, vif.vram_wdata);
    else passed++;
    checks++;
    if (vif.err !== 3'b001) $display("FAIL ovf_err: got %b expected 001", vif.err);
    else passed++;
    vif.vram_ready = 1'b1;
    wait_done(8, lat);
    checks++;
    if (lat !== 2) $display("FAIL ovf_done_latency: got %0d expected 2", lat);
    else passed++;
    tick();
    checks++;
    if (exp_q.size() !== 0 || done_cnt !== 1 || vif.err !== 3'b001)
      $display("FAIL ovf_final: got pending=%0d done=%0d err=%b expected 0 1 001", exp_q.size(), done_cnt, vif.err);
    else passed++;
  endtask

  task automatic test_timeout();
    int lat;
    vif.vram_ready = 1'b1;
    done_cnt = 0;
    expect_wr(8'h30, 32'h1234_5678);
    send_begin(8'd2, 8'h30);
    send_cont(32'h1234_5678);
    repeat (15) tick();
    checks++;
    if (vif.err !== 3'b000 || vif.busy !== 1'b1)
      $display("FAIL tmo_before: got err=%b busy=%b expected 000 1", vif.err, vif.busy);
    else passed++;
    tick();
    checks++;
    if (vif.err !== 3'b100 || vif.busy !== 1'b0)
      $display("FAIL tmo_fire: got err=%b busy=%b expected 100 0", vif.err, vif.busy);
    else passed++;
    repeat (4) tick();
    checks++;
    if (done_cnt !== 0 || exp_q.size() !== 0)
      $display("FAIL tmo_no_done: got done=%0d pending=%0d expected 0 0", done_cnt, exp_q.size());
    else passed++;
    expect_wr(8'h40, 32'h0BAD_F00D);
    send_begin(8'd1, 8'h40);
    checks++;
    if (vif.err !== 3'b000 || vif.busy !== 1'b1)
      $display("FAIL tmo_err_clear: got err=%b busy=%b expected 000 1", vif.err, vif.busy);
    else passed++;
    send_cont(32'h0BAD_F00D);
    wait_done(8, lat);
    checks++;
    if (lat !== 1) $display("FAIL tmo_next_load: got latency %0d expected 1", lat);
    else passed++;
    tick();
  endtask

  task automatic test_extra_cont();
    int lat;
    vif.vram_ready = 1'b0;
    expect_wr(8'h50, 32'h5555_AAAA);
    send_begin(8'd1, 8'h50);
    send_cont(32'h5555_AAAA);
    send_cont(32'h6666_BBBB);
    checks++;
    if (vif.err !== 3'b010 || vif.vram_wdata !== 32'h5555_AAAA)
      $display("FAIL xcont_err: got err=%b data=%h expected 010 5555aaaa", vif.err, vif.vram_wdata);
    else passed++;
    vif.vram_ready = 1'b1;
    wait_done(8, lat);
    checks++;
    if (lat !== 1) $display("FAIL xcont_done_latency: got %0d expected 1", lat);
    else passed++;
    tick();
    checks++;
    if (exp_q.size() !== 0 || vif.err !== 3'b010)
      $display("FAIL xcont_final: got pending=%0d err=%b expected 0 010", exp_q.size(), vif.err);
    else passed++;
  endtask

  task automatic test_zero_count();
    repeat (3) tick();
    busy_seen = 1'b0;
    we_seen = 1'b0;
    done_cnt = 0;
    send_begin(8'd0, 8'h60);
    checks++;
    if (vif.done !== 1'b1 || vif.busy !== 1'b0)
      $display("FAIL zero_done: got done=%b busy=%b expected 1 0", vif.done, vif.busy);
    else passed++;
    tick();
    checks++;
    if (vif.done !== 1'b0) $display("FAIL zero_done_pulse: got %b expected 0", vif.done);
    else passed++;
    repeat (3) tick();
    checks++;
    if (done_cnt !== 1 || busy_seen || we_seen)
      $display("FAIL zero_quiet: got done=%0d busy_seen=%b we_seen=%b expected 1 0 0", done_cnt, busy_seen, we_seen);
    else passed++;
  endtask

  task automatic test_reset_mid_load();
    vif.vram_ready = 1'b0;
    send_begin(8'd4, 8'h70);
    send_cont(32'h0000_0007);
    send_cont(32'h0000_0008);
    send_cont(32'h0000_0009);
    checks++;
    if (vif.busy !== 1'b1 || vif.vram_we !== 1'b1 || vif.err !== 3'b001)
      $display("FAIL rst_setup: got busy=%b we=%b err=%b expected 1 1 001", vif.busy, vif.vram_we, vif.err);
    else passed++;
    rst = 1'b1;
    tick();
    checks++;
    if ({vif.busy, vif.vram_we, vif.done, vif.err, vif.vram_addr, vif.vram_wdata, vif.vertex_count} !== 54'h0)
      $display("FAIL rst_mid_load: got busy=%b we=%b done=%b err=%b addr=%h data=%h vcnt=%h expected all 0",
               vif.busy, vif.vram_we, vif.done, vif.err, vif.vram_addr, vif.vram_wdata, vif.vertex_count);
    else passed++;
    rst = 1'b0;
    exp_q.delete();
    vif.vram_ready = 1'b1;
    we_seen = 1'b0;
    repeat (4) tick();
    checks++;
    if (we_seen || vif.busy !== 1'b0)
      $display("FAIL rst_flushed: got we_seen=%b busy=%b expected 0 0", we_seen, vif.busy);
    else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_overflow();
    test_timeout();
    test_extra_cont();
    test_zero_count();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
